// File: rtl/y86_fetch_queue.sv
// Y86-64 fetch queue: byte ring prefetch, length decode, 80-bit window; optional Y86_FETCHQ_STATS_EN counters.
// Window is combinational from the head, valid the cycle after covering beats land; holds while !inst_ready.
module y86_fetch_queue #(
  parameter int          DEPTH       = 16,
  parameter int          FETCH_BYTES = 4,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [63:0]              mem_addr,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [8*FETCH_BYTES-1:0] mem_rdata,
  input  logic                     mem_err,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [79:0]              inst_bytes,
  output logic [63:0]              inst_pc,
  output logic [3:0]               inst_len,
  output logic                     inst_bad,
  output logic                     imem_err,
  input  logic                     redirect,
  input  logic [63:0]              redirect_pc
`ifdef Y86_FETCHQ_STATS_EN
  ,
  output logic [31:0]              stat_stall,
  output logic [31:0]              stat_flush,
  output logic [31:0]              stat_inst
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FB_C    = CW'(FETCH_BYTES);
  localparam logic [63:0]   FB_PC   = 64'(FETCH_BYTES);

  logic [7:0]    byte_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   head_pc_q, head_pc_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic          outst_q, outst_d;
  logic          drop_q, drop_d;
  logic          err_pend_q, err_pend_d;

  logic [7:0]    win [10];
  logic [3:0]    len_w;
  logic          bad_w;
  logic [CW-1:0] len_c;
  logic [CW-1:0] resv;
  logic [CW-1:0] space;
  logic [PW-1:0] tail;
  logic          full_inst, err_win;
  logic          accept, push, rsp_err, pop;

  // Bytes past the filled count read as zero so stale ring contents never leak.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      win[i] = (CW'(i) < count_q) ? byte_q[head_q + PW'(i)] : 8'h00;
      inst_bytes[79-8*i -: 8] = win[i];
    end
  end

  always_comb begin
    len_w = 4'd1;
    bad_w = 1'b0;
    case (win[0][7:4])
      4'h0, 4'h1, 4'h9:       len_w = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len_w = 4'd2;
      4'h7, 4'h8:             len_w = 4'd9;
      4'h3, 4'h4, 4'h5:       len_w = 4'd10;
      default:                bad_w = 1'b1;
    endcase
  end

  assign len_c      = CW'(len_w);
  assign full_inst  = (count_q != '0) && (count_q >= len_c);
  assign err_win    = err_pend_q && (count_q < len_c);
  assign inst_valid = full_inst || err_win;
  assign imem_err   = err_win;
  assign inst_bad   = bad_w && (count_q != '0);
  assign inst_len   = len_w;
  assign inst_pc    = head_pc_q;

  // Space accounts for the in-flight beat so a response always has room.
  assign resv     = outst_q ? FB_C : '0;
  assign space    = DEPTH_C - count_q - resv;
  assign mem_req  = !rst && !outst_q && !drop_q && !err_pend_q && !redirect && (space >= FB_C);
  assign mem_addr = fetch_pc_q;

  assign accept  = mem_req && mem_ready;
  assign push    = mem_rvalid && !drop_q && !mem_err;
  assign rsp_err = mem_rvalid && !drop_q && mem_err;
  assign pop     = inst_valid && inst_ready && !imem_err && !redirect;
  assign tail    = head_q + count_q[PW-1:0];

  always_comb begin
    head_d     = head_q;
    count_d    = count_q;
    head_pc_d  = head_pc_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    err_pend_d = err_pend_q;
    if (mem_rvalid) begin
      if (drop_q) drop_d = 1'b0;
      else        outst_d = 1'b0;
    end
    if (rsp_err) err_pend_d = 1'b1;
    if (accept) begin
      outst_d    = 1'b1;
      fetch_pc_d = fetch_pc_q + FB_PC;
    end
    count_d = count_q + (push ? FB_C : '0) - (pop ? len_c : '0);
    if (pop) begin
      head_d    = head_q + PW'(len_w);
      head_pc_d = head_pc_q + 64'(len_w);
    end
    // A beat still owed by memory becomes stale and must be swallowed.
    if (redirect) begin
      count_d    = '0;
      head_pc_d  = redirect_pc;
      fetch_pc_d = redirect_pc;
      err_pend_d = 1'b0;
      drop_d     = drop_d | outst_d;
      outst_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      count_q    <= '0;
      head_pc_q  <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      outst_q    <= 1'b0;
      drop_q     <= (outst_q | drop_q) & ~mem_rvalid;
      err_pend_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      count_q    <= count_d;
      head_pc_q  <= head_pc_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      err_pend_q <= err_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !redirect) begin
      for (int i = 0; i < FETCH_BYTES; i++) begin
        byte_q[tail + PW'(i)] <= mem_rdata[8*i +: 8];
      end
    end
  end

`ifdef Y86_FETCHQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall <= '0;
      stat_flush <= '0;
      stat_inst  <= '0;
    end else begin
      if (inst_ready && !inst_valid && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
      if (redirect && stat_flush != '1)                  stat_flush <= stat_flush + 32'd1;
      if (pop && stat_inst != '1)                        stat_inst  <= stat_inst + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_y86_fetch_queue.sv
// Directed bench for y86_fetch_queue: negedge memory model with settable latency and error address.
module tb_y86_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready;
  logic [79:0] inst_bytes;
  logic [63:0] inst_pc;
  logic [3:0]  inst_len;
  logic        inst_bad;
  logic        imem_err;
  logic        redirect;
  logic [63:0] redirect_pc;
`ifdef Y86_FETCHQ_STATS_EN
  logic [31:0] stat_stall, stat_flush, stat_inst;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [1024];
  int          lat = 1;
  logic        pend = 1'b0;
  int          tmr = 0;
  logic [63:0] paddr = '0;
  logic [63:0] acc_addr [64];
  int          acc_cnt = 0;
  logic        err_en = 1'b0;
  logic [63:0] err_addr = '0;

  y86_fetch_queue #(.DEPTH(16), .FETCH_BYTES(4), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_bytes(inst_bytes),
    .inst_pc(inst_pc), .inst_len(inst_len), .inst_bad(inst_bad), .imem_err(imem_err),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef Y86_FETCHQ_STATS_EN
    , .stat_stall(stat_stall), .stat_flush(stat_flush), .stat_inst(stat_inst)
`endif
  );

  always #5 clk = ~clk;

  // Memory: accepts any request seen at the falling edge, answers lat falling edges later.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    mem_rdata  = '0;
    if (pend) begin
      if (tmr <= 1) begin
        mem_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) mem_rdata[8*i +: 8] = mem[paddr[9:0] + 10'(i)];
        mem_err = err_en && (paddr == err_addr);
        pend = 1'b0;
      end else begin
        tmr = tmr - 1;
      end
    end
    mem_ready = 1'b0;
    if (mem_req) begin
      if (pend) begin
        errors++;
        $display("FAIL mem_protocol: request at %0h while beat outstanding, want none", mem_addr);
      end
      mem_ready = 1'b1;
      pend = 1'b1;
      tmr = lat;
      paddr = mem_addr;
      if (acc_cnt < 64) acc_addr[acc_cnt] = mem_addr;
      acc_cnt++;
    end
  end

  task automatic do_reset();
    rst = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    acc_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic pop1();
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (inst_valid) break;
      @(posedge clk); #1;
    end
    checks++;
    if (inst_valid !== 1'b1) begin errors++; $display("FAIL wait_valid: inst_valid=%0b want 1 within %0d cycles", inst_valid, budget); end
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    inst_ready = 1'b0; redirect = 1'b1; redirect_pc = pc;
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", inst_valid); end
    checks++; if (inst_bad !== 1'b0) begin errors++; $display("FAIL reset_bad: got %0b want 0", inst_bad); end
    checks++; if (imem_err !== 1'b0) begin errors++; $display("FAIL reset_imem_err: got %0b want 0", imem_err); end
    checks++; if (inst_bytes !== 80'h0) begin errors++; $display("FAIL reset_bytes: got %h want 0", inst_bytes); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
    checks++; if (inst_pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
  endtask

  task automatic test_full();
    lat = 1;
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_mem_req: got %0b want 0", mem_req); end
    checks++; if (acc_cnt !== 4) begin errors++; $display("FAIL full_beats: got %0d want 4", acc_cnt); end
    checks++; if (inst_bytes !== 80'h30F20A00000000000000) begin errors++; $display("FAIL full_bytes: got %h want 30f20a00000000000000", inst_bytes); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (inst_bytes !== 80'h30F20A00000000000000) begin errors++; $display("FAIL full_hold: got %h want 30f20a00000000000000", inst_bytes); end
  endtask

  task automatic test_basic();
    wait_valid(30);
    checks++; if (inst_pc !== 64'd0) begin errors++; $display("FAIL basic_pc0: got %h want 0", inst_pc); end
    checks++; if (inst_len !== 4'd10) begin errors++; $display("FAIL basic_len0: got %0d want 10", inst_len); end
    pop1();
    wait_valid(30);
    checks++; if (inst_pc !== 64'd10) begin errors++; $display("FAIL basic_pc10: got %h want a", inst_pc); end
    checks++; if (inst_len !== 4'd1) begin errors++; $display("FAIL basic_len10: got %0d want 1", inst_len); end
    checks++; if (inst_bytes !== {8'h10, 72'h0}) begin errors++; $display("FAIL basic_bytes10: got %h want 10 then zeros", inst_bytes); end
    pop1();
    wait_valid(30);
    checks++; if (inst_pc !== 64'd11) begin errors++; $display("FAIL basic_pc11: got %h want b", inst_pc); end
    checks++; if (inst_bytes !== 80'h0) begin errors++; $display("FAIL basic_bytes11: got %h want 0", inst_bytes); end
  endtask

  task automatic test_redirect_drop();
    lat = 3;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (acc_cnt >= 1) break;
      @(posedge clk); #1;
    end
    checks++; if (acc_cnt !== 1) begin errors++; $display("FAIL drop_setup: beats accepted %0d want 1", acc_cnt); end
    lat = 1;
    do_redirect(64'h40);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL drop_valid_after_redirect: got %0b want 0", inst_valid); end
    wait_valid(40);
    checks++; if (acc_addr[1] !== 64'h40) begin errors++; $display("FAIL drop_req_addr: got %h want 40", acc_addr[1]); end
    checks++; if (inst_pc !== 64'h40) begin errors++; $display("FAIL drop_pc: got %h want 40", inst_pc); end
    checks++; if (inst_bytes[79:64] !== 16'h6012) begin errors++; $display("FAIL drop_bytes: got %h want 6012", inst_bytes[79:64]); end
    checks++; if (inst_len !== 4'd2) begin errors++; $display("FAIL drop_len: got %0d want 2", inst_len); end
    pop1();
    wait_valid(30);
    checks++; if (inst_pc !== 64'h42) begin errors++; $display("FAIL drop_pc2: got %h want 42", inst_pc); end
    checks++; if (inst_bytes[79:64] !== 16'h2034) begin errors++; $display("FAIL drop_bytes2: got %h want 2034", inst_bytes[79:64]); end
  endtask

  task automatic test_mem_err();
    err_en = 1'b1; err_addr = 64'h108;
    do_redirect(64'h100);
    inst_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (inst_valid && imem_err) break;
      @(posedge clk); #1;
    end
    checks++; if (imem_err !== 1'b1) begin errors++; $display("FAIL err_flag: got %0b want 1", imem_err); end
    checks++; if (inst_pc !== 64'h107) begin errors++; $display("FAIL err_pc: got %h want 107", inst_pc); end
    checks++; if (inst_bytes !== {8'h60, 72'h0}) begin errors++; $display("FAIL err_bytes: got %h want 60 then zeros", inst_bytes); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (inst_valid !== 1'b1 || imem_err !== 1'b1) begin errors++; $display("FAIL err_hold: valid=%0b err=%0b want 1 1", inst_valid, imem_err); end
    checks++; if (inst_pc !== 64'h107) begin errors++; $display("FAIL err_hold_pc: got %h want 107", inst_pc); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL err_mem_req: got %0b want 0", mem_req); end
    err_en = 1'b0;
    do_redirect(64'h180);
    checks++; if (inst_valid !== 1'b0 || imem_err !== 1'b0) begin errors++; $display("FAIL err_clear: valid=%0b err=%0b want 0 0", inst_valid, imem_err); end
  endtask

  task automatic test_bad();
    do_redirect(64'h200);
    wait_valid(30);
    checks++; if (inst_pc !== 64'h200) begin errors++; $display("FAIL bad_pc: got %h want 200", inst_pc); end
    checks++; if (inst_bad !== 1'b1) begin errors++; $display("FAIL bad_flag: got %0b want 1", inst_bad); end
    checks++; if (inst_len !== 4'd1) begin errors++; $display("FAIL bad_len: got %0d want 1", inst_len); end
    pop1();
    wait_valid(30);
    checks++; if (inst_pc !== 64'h201) begin errors++; $display("FAIL bad_next_pc: got %h want 201", inst_pc); end
    checks++; if (inst_bad !== 1'b0) begin errors++; $display("FAIL bad_next_flag: got %0b want 0", inst_bad); end
  endtask

  task automatic test_wrap();
    do_reset();
    do_redirect(64'h300);
    inst_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (inst_valid && inst_pc == 64'h30C) break;
      @(posedge clk); #1;
    end
    inst_ready = 1'b0;
    checks++; if (inst_pc !== 64'h30C || inst_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc: got %h valid %0b want 30c 1", inst_pc, inst_valid); end
    checks++; if (inst_len !== 4'd10) begin errors++; $display("FAIL wrap_len: got %0d want 10", inst_len); end
    checks++; if (inst_bytes !== 80'h30F31122334455667788) begin errors++; $display("FAIL wrap_bytes: got %h want 30f31122334455667788", inst_bytes); end
`ifdef Y86_FETCHQ_STATS_EN
    checks++; if (stat_flush !== 32'd1) begin errors++; $display("FAIL stat_flush: got %0d want 1", stat_flush); end
    checks++; if (stat_inst !== 32'd12) begin errors++; $display("FAIL stat_inst: got %0d want 12", stat_inst); end
`endif
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A; mem[10] = 8'h10;
    mem[12'h40] = 8'h60; mem[12'h41] = 8'h12; mem[12'h42] = 8'h20; mem[12'h43] = 8'h34;
    for (int a = 12'h100; a < 12'h107; a++) mem[a] = 8'h10;
    mem[12'h107] = 8'h60; mem[12'h108] = 8'h12;
    mem[12'h200] = 8'hC0; mem[12'h201] = 8'h10;
    for (int a = 12'h300; a < 12'h30C; a++) mem[a] = 8'h10;
    mem[12'h30C] = 8'h30; mem[12'h30D] = 8'hF3; mem[12'h30E] = 8'h11; mem[12'h30F] = 8'h22;
    mem[12'h310] = 8'h33; mem[12'h311] = 8'h44; mem[12'h312] = 8'h55; mem[12'h313] = 8'h66;
    mem[12'h314] = 8'h77; mem[12'h315] = 8'h88;

    test_reset();
    test_full();
    test_basic();
    test_redirect_drop();
    test_mem_err();
    test_bad();
    test_wrap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
